// File: rtl/mem_stage.sv
// mem_stage: RISC-V memory stage; aligned dmem requests, load extension, store lane steering.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] alu_out,
  input  logic [DWIDTH-1:0] store_data,
  input  logic [4:0]        rd,
  input  logic              ctrl_reg_we,
  input  logic              ctrl_mem_read,
  input  logic              ctrl_mem_write,
  input  logic [2:0]        func3,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [AWIDTH-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [DWIDTH-1:0] dmem_wdata,
  output logic [3:0]        dmem_wbe,
  input  logic              dmem_resp_valid,
  input  logic [DWIDTH-1:0] dmem_resp_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DWIDTH-1:0] wb_data,
  output logic              misaligned
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [1:0] addr_lo;
  logic [4:0] rd_q;
  logic we_q, byte_q, half_q, uns_q;
  logic mem, is_byte, is_half, mis, rd_we;
  logic [DWIDTH-1:0] wdata_n, lane, load_val;
  logic [3:0] wbe_n;
  logic [1:0] sel;
  assign in_ready = state == IDLE;
  assign dmem_req_valid = state == REQ;
  assign mem = ctrl_mem_read | ctrl_mem_write;
  assign rd_we = ctrl_reg_we && rd != 5'd0;
  // Unlisted func3 codes fall through to word width.
  assign is_byte = func3 == 3'b000 || (ctrl_mem_read && func3 == 3'b100);
  assign is_half = func3 == 3'b001 || (ctrl_mem_read && func3 == 3'b101);
`ifdef MISALIGN_TRAP_EN
  assign mis = mem && (is_half ? alu_out[0] : !is_byte && alu_out[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    wdata_n = is_byte ? {4{store_data[7:0]}} : is_half ? {2{store_data[15:0]}} : store_data;
    wbe_n = ctrl_mem_read ? 4'b0000 :
            is_byte ? 4'b0001 << alu_out[1:0] :
            is_half ? 4'b0011 << {alu_out[1], 1'b0} : 4'b1111;
  end
  always_comb begin
    sel = byte_q ? addr_lo : half_q ? {addr_lo[1], 1'b0} : 2'b00;
    lane = dmem_resp_rdata >> {sel, 3'b000};
    load_val = byte_q ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
               half_q ? {{16{~uns_q & lane[15]}}, lane[15:0]} : dmem_resp_rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_lo    <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      half_q     <= 1'b0;
      uns_q      <= 1'b0;
      dmem_addr  <= '0;
      dmem_we    <= 1'b0;
      dmem_wdata <= '0;
      dmem_wbe   <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      misaligned <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          rd_q    <= rd;
          we_q    <= rd_we;
          addr_lo <= alu_out[1:0];
          byte_q  <= is_byte;
          half_q  <= is_half;
          uns_q   <= func3[2];
          if (!mem) begin
            wb_valid <= 1'b1;
            wb_we    <= rd_we;
            wb_rd    <= rd;
            wb_data  <= alu_out;
          end else if (mis) begin
            wb_valid   <= 1'b1;
            wb_we      <= 1'b0;
            wb_rd      <= rd;
            misaligned <= 1'b1;
          end else begin
            state      <= REQ;
            dmem_addr  <= {alu_out[AWIDTH-1:2], 2'b00};
            dmem_we    <= !ctrl_mem_read;
            dmem_wdata <= wdata_n;
            dmem_wbe   <= wbe_n;
          end
        end
        REQ: if (dmem_req_ready) begin
          if (dmem_we) begin
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            wb_rd    <= rd_q;
            state    <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        RESP: if (dmem_resp_valid) begin
          wb_valid <= 1'b1;
          wb_we    <= we_q;
          wb_rd    <= rd_q;
          wb_data  <= load_val;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; expected writebacks queued at issue, checked on wb_valid.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready;
  logic [31:0] alu_out, store_data;
  logic [4:0] rd;
  logic ctrl_reg_we, ctrl_mem_read, ctrl_mem_write;
  logic [2:0] func3;
  logic dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr;
  logic dmem_we;
  logic [31:0] dmem_wdata;
  logic [3:0] dmem_wbe;
  logic dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;
  logic wb_valid, wb_we;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic misaligned;
  int vectors = 0;
  int miscompares = 0;
  typedef struct packed {
    logic we;
    logic [4:0] rd;
    logic [31:0] data;
    logic chk_data;
    logic mis;
  } wb_t;
  wb_t q[$];
  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .store_data(store_data), .rd(rd), .ctrl_reg_we(ctrl_reg_we),
    .ctrl_mem_read(ctrl_mem_read), .ctrl_mem_write(ctrl_mem_write), .func3(func3),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_wbe(dmem_wbe),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (q.size() == 0) check("wb_unexpected", 1, 0);
      else begin
        wb_t e;
        e = q.pop_front();
        check("wb_we", wb_we, e.we);
        check("wb_rd", wb_rd, e.rd);
        if (e.chk_data) check("wb_data", wb_data, e.data);
        check("wb_misaligned", misaligned, e.mis);
      end
    end
  end
  task automatic send(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sd, input logic [4:0] r, input logic rwe);
    in_valid = 1'b1; ctrl_mem_read = ld; ctrl_mem_write = st; func3 = f3;
    alu_out = a; store_data = sd; rd = r; ctrl_reg_we = rwe;
    @(posedge clk); #1;
    in_valid = 1'b0; ctrl_mem_read = 1'b0; ctrl_mem_write = 1'b0;
  endtask
  task automatic alu(input logic [31:0] a, input logic [4:0] r, input logic rwe);
    q.push_back('{rwe && r != 0, r, a, 1'b1, 1'b0});
    send(1'b0, 1'b0, 3'b000, a, 32'h0, r, rwe);
  endtask
  task automatic mem_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] r, input logic rwe,
                        input int rdly, input int pdly, input logic [31:0] rdata,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wbe,
                        input logic [31:0] exp_data);
    q.push_back(ld ? '{rwe && r != 0, r, exp_data, 1'b1, 1'b0} : '{1'b0, r, 32'h0, 1'b0, 1'b0});
    send(ld, st, f3, a, sd, r, rwe);
    for (int i = 0; i <= rdly; i++) begin
      dmem_req_ready = (i == rdly);
      dmem_resp_valid = (i < rdly);
      dmem_resp_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("req_valid", dmem_req_valid, 1);
      check("req_in_ready", in_ready, 0);
      check("req_addr", dmem_addr, {a[31:2], 2'b00});
      check("req_we", dmem_we, !ld);
      check("req_wbe", dmem_wbe, exp_wbe);
      if (!ld) check("req_wdata", dmem_wdata, exp_wdata);
      @(posedge clk); #1;
    end
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    if (ld) begin
      for (int j = 0; j < pdly; j++) begin
        @(negedge clk);
        check("resp_req_valid", dmem_req_valid, 0);
        check("resp_in_ready", in_ready, 0);
        @(posedge clk); #1;
      end
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = rdata;
      @(posedge clk); #1;
      dmem_resp_valid = 1'b0;
    end
    @(negedge clk);
    check("done_in_ready", in_ready, 1);
    @(posedge clk); #1;
  endtask
  task automatic reset_mid(input logic in_resp);
    send(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd9, 1'b1);
    if (in_resp) begin
      dmem_req_ready = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
    end
    @(negedge clk);
    check("pre_rst_req_valid", dmem_req_valid, !in_resp);
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_valid", dmem_req_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_req_valid", dmem_req_valid, 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_out = '0; store_data = '0; rd = '0;
    ctrl_reg_we = 1'b0; ctrl_mem_read = 1'b0; ctrl_mem_write = 1'b0; func3 = '0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_wb_valid0", wb_valid, 0);
    check("rst_wb_we0", wb_we, 0);
    check("rst_wb_data0", wb_data, 0);
    check("rst_dmem_req0", dmem_req_valid, 0);
    check("rst_dmem_addr0", dmem_addr, 0);
    check("rst_dmem_wbe0", dmem_wbe, 0);
    check("rst_mis0", misaligned, 0);
    check("rst_in_ready0", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    alu(32'h0000_1234, 5'd5, 1'b1);
    alu(32'h0000_5678, 5'd0, 1'b1);
    alu(32'hCAFE_0001, 5'd31, 1'b0);
    mem_op(1'b0, 1'b1, 3'b000, 32'h1003, 32'h0000_00AB, 5'd3, 1'b1, 3, 0, 0, 32'hABAB_ABAB, 4'b1000, 0);
    mem_op(1'b0, 1'b1, 3'b001, 32'h1002, 32'h1234_CDEF, 5'd3, 1'b0, 0, 0, 0, 32'hCDEF_CDEF, 4'b1100, 0);
    mem_op(1'b0, 1'b1, 3'b010, 32'h1008, 32'h8765_4321, 5'd3, 1'b0, 1, 0, 0, 32'h8765_4321, 4'b1111, 0);
    mem_op(1'b1, 1'b0, 3'b000, 32'h2001, 0, 5'd7, 1'b1, 0, 2, 32'h0000_8000, 0, 4'b0000, 32'hFFFF_FF80);
    mem_op(1'b1, 1'b0, 3'b100, 32'h2001, 0, 5'd7, 1'b1, 1, 2, 32'h0000_8000, 0, 4'b0000, 32'h0000_0080);
    mem_op(1'b1, 1'b0, 3'b001, 32'h2002, 0, 5'd8, 1'b1, 0, 0, 32'h8001_0000, 0, 4'b0000, 32'hFFFF_8001);
    mem_op(1'b1, 1'b0, 3'b101, 32'h2002, 0, 5'd8, 1'b1, 2, 1, 32'h8001_0000, 0, 4'b0000, 32'h0000_8001);
    mem_op(1'b1, 1'b0, 3'b000, 32'h2003, 0, 5'd4, 1'b1, 0, 0, 32'h7F00_00FF, 0, 4'b0000, 32'h0000_007F);
    mem_op(1'b1, 1'b0, 3'b001, 32'h2000, 0, 5'd0, 1'b1, 0, 0, 32'h1234_7ABC, 0, 4'b0000, 32'h0000_7ABC);
    mem_op(1'b1, 1'b0, 3'b111, 32'h2004, 0, 5'd6, 1'b1, 0, 0, 32'h1357_9BDF, 0, 4'b0000, 32'h1357_9BDF);
    mem_op(1'b1, 1'b1, 3'b010, 32'h2008, 32'hFFFF_FFFF, 5'd6, 1'b1, 0, 1, 32'h2468_ACE0, 0, 4'b0000, 32'h2468_ACE0);
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    mem_op(1'b1, 1'b0, 3'b010, 32'h2010, 0, 5'd10, 1'b1, 0, 1, 32'h0102_0304, 0, 4'b0000, 32'h0102_0304);
    alu(32'h0000_00AA, 5'd1, 1'b1);
`ifdef MISALIGN_TRAP_EN
    q.push_back('{1'b0, 5'd11, 32'h0, 1'b0, 1'b1});
    send(1'b1, 1'b0, 3'b010, 32'h3002, 0, 5'd11, 1'b1);
    @(negedge clk);
    check("mis_no_req", dmem_req_valid, 0);
    check("mis_in_ready", in_ready, 1);
    @(posedge clk); #1;
    q.push_back('{1'b0, 5'd12, 32'h0, 1'b0, 1'b1});
    send(1'b0, 1'b1, 3'b001, 32'h3001, 32'h55, 5'd12, 1'b0);
    @(negedge clk);
    check("mis_sh_no_req", dmem_req_valid, 0);
    @(posedge clk); #1;
`else
    mem_op(1'b1, 1'b0, 3'b010, 32'h3002, 0, 5'd11, 1'b1, 0, 0, 32'h0BAD_F00D, 0, 4'b0000, 32'h0BAD_F00D);
    mem_op(1'b1, 1'b0, 3'b001, 32'h3003, 0, 5'd12, 1'b1, 0, 0, 32'hFEDC_0000, 0, 4'b0000, 32'hFFFF_FEDC);
    mem_op(1'b0, 1'b1, 3'b001, 32'h3001, 32'h0000_5A5A, 5'd2, 1'b0, 0, 0, 0, 32'h5A5A_5A5A, 4'b0011, 0);
`endif
    reset_mid(1'b0);
    reset_mid(1'b1);
    alu(32'h0000_0777, 5'd2, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the RISC-V core pipeline, directly downstream of the execute stage.
- Consumes the ALU result (address or arithmetic result), the store data (rs2) and control bits from the execute stage.
- Issues aligned data-memory requests over a valid/ready port and waits for variable-latency responses.
- Performs load lane extraction with sign/zero extension and store byte-lane steering.
- Presents a registered writeback bundle to the writeback stage.

Parameters:
DWIDTH, 32, data path width (byte lane logic fixed at 4 lanes)
AWIDTH, 32, data memory address width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  execute stage has an instruction
in_ready  output  1  stage can accept; = (state==IDLE)
alu_out  input  DWIDTH  ALU result / effective address
store_data  input  DWIDTH  rs2 data for stores
rd  input  5  destination register
ctrl_reg_we  input  1  instruction writes rd
ctrl_mem_read  input  1  load
ctrl_mem_write  input  1  store
func3  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
dmem_req_valid  output  1  request valid
dmem_req_ready  input  1  memory accepts request
dmem_addr  output  AWIDTH  word-aligned address {addr[AWIDTH-1:2],2'b00}
dmem_we  output  1  1=store, 0=load
dmem_wdata  output  DWIDTH  lane-replicated store data
dmem_wbe  output  4  byte write enables
dmem_resp_valid  input  1  load data valid
dmem_resp_rdata  input  DWIDTH  load word
wb_valid  output  1  one-cycle retire pulse
wb_we  output  1  register-file write enable
wb_rd  output  5  destination register
wb_data  output  DWIDTH  writeback value
misaligned  output  1  misaligned access pulse (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): state=IDLE. All registered outputs are 0: wb_*, dmem_*, misaligned. An in-flight access is dropped and dmem_req_valid deasserts immediately.
- FSM states: IDLE, REQ, RESP.
- IDLE: in_ready=1. On in_valid, the instruction is captured and dispatched:
  - No memory bit set: next cycle wb_valid=1, wb_data=alu_out, wb_we=ctrl_reg_we&(rd!=0). State stays IDLE. Throughput is 1 instruction per cycle.
  - Load or store: go to REQ; in_ready=0 until the state returns to IDLE.
  - ctrl_mem_read and ctrl_mem_write both set: treated as a load.
- REQ: dmem_req_valid=1. dmem_addr, dmem_we, dmem_wdata and dmem_wbe are held stable until dmem_req_ready.
  - Store handshake: next cycle wb_valid=1, wb_we=0; go to IDLE.
  - Load handshake: go to RESP.
- RESP: wait for dmem_resp_valid. On a response:
  - Byte/half is selected by the captured addr[1:0] and extended per func3.
  - Next cycle wb_valid=1, wb_data=extended value, wb_we=ctrl_reg_we&(rd!=0); go to IDLE.
- dmem_resp_valid in IDLE or REQ is ignored.
- Store steering:
  - SB: wdata={4{b}}, wbe=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, wbe=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=store_data, wbe=4'b1111.
  - Loads drive wbe=0.
- Latency: non-memory 1 cycle; store 1+N cycles (N = request-wait cycles); load ≥3 cycles.
- wb_valid is a single-cycle pulse. wb_* hold their value otherwise, with wb_valid=0.
- func3 not in the load/store set: treated as W.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issues no dmem request.
  - Next cycle wb_valid=1, wb_we=0, misaligned=1 (single-cycle pulse); state stays IDLE.
- Undefined:
  - misaligned is tied 0.
  - Halfword accesses use addr[1] only; word accesses ignore addr[1:0]; the access proceeds normally.

Test Plan:
- ADD result alu_out=0x1234, rd=5, reg_we=1, back-to-back with rd=0 → wb_valid on consecutive cycles; wb_data=0x1234, wb_we=1; then wb_we=0 for rd=0.
- SB addr=0x1003, store_data=0xAB, dmem_req_ready delayed 3 cycles → dmem_addr=0x1000, wdata=0xABABABAB, wbe=4'b1000, stable all 4 cycles; wb_valid with wb_we=0 after the handshake; in_ready=0 throughout.
- LB addr=0x2001, resp rdata=0x0000_8000 after 2 cycles → wb_data=0xFFFF_FF80. LBU on the same data → 0x0000_0080. LH addr=0x2002, rdata=0x8001_0000 → 0xFFFF_8001.
- Spurious dmem_resp_valid in IDLE, then LW → the spurious response is ignored; wb_data equals the response received in RESP.
- Assert rst_n low during RESP → dmem_req_valid=0, wb_valid=0 immediately; after release state=IDLE and in_ready=1.
- With MISALIGN_TRAP_EN, LW addr=0x3002 → no dmem_req_valid; next cycle wb_valid=1, misaligned=1, wb_we=0. Without the macro → dmem_addr=0x3000, normal load.
